// File: rtl/seq_shifter.sv
// Multi-cycle barrel-less shifter: SLL/SRL/SRA/ROTL performed STEP bit positions per cycle.
// A three-state FSM (IDLE/SHIFT/DONE) sequences the operation and registers the result.
module seq_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int STEP        = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  in,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRL  = 2'b01;
    localparam logic [1:0] MODE_SRA  = 2'b10;
    localparam logic [1:0] MODE_ROTL = 2'b11;

    // One extra bit so STEP and DATA_WIDTH themselves are representable.
    localparam logic [SHAMT_WIDTH:0] STEP_W  = (SHAMT_WIDTH+1)'(STEP);
    localparam logic [SHAMT_WIDTH:0] WIDTH_W = (SHAMT_WIDTH+1)'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    state_t                  state;
    state_t                  next_state;
    logic [DATA_WIDTH-1:0]   work;
    logic [1:0]              mode_r;
    logic                    sign_r;
    logic [SHAMT_WIDTH:0]    remaining;
    logic [SHAMT_WIDTH:0]    k;
    logic [DATA_WIDTH-1:0]   shifted;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (remaining == k) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Step size for this cycle is the smaller of what is left and STEP.
    always_comb begin
        k       = (remaining < STEP_W) ? remaining : STEP_W;
        shifted = work;
        case (mode_r)
            MODE_SLL:  shifted = work << k;
            MODE_SRL:  shifted = work >> k;
            MODE_SRA:  shifted = (work >> k) | (sign_r ? ~(ALL_ONES >> k) : '0);
            MODE_ROTL: shifted = (work << k) | (work >> (WIDTH_W - k));
            default:   shifted = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work      <= '0;
            mode_r    <= '0;
            sign_r    <= 1'b0;
            remaining <= '0;
            out       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work      <= in;
                        mode_r    <= mode;
                        sign_r    <= in[DATA_WIDTH-1];
                        remaining <= {1'b0, shamt};
                        if (shamt == '0) begin
                            out <= in;
                        end
                    end
                end
                ST_SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - k;
                    if (remaining == k) begin
                        out <= shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter: one instance with STEP=1 and one with STEP=4
// share operand inputs but have separate start strobes.
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start1;
    logic        start4;
    logic [1:0]  mode;
    logic [4:0]  shamt;
    logic [31:0] in;
    logic        busy1, done1, busy4, done4;
    logic [31:0] out1, out4;

    logic        sel4;
    logic        obs_busy, obs_done;
    logic [31:0] obs_out;

    int compared;
    int mismatched;

    seq_shifter #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .shamt(shamt),
        .in(in), .busy(busy1), .done(done1), .out(out1)
    );

    seq_shifter #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .shamt(shamt),
        .in(in), .busy(busy4), .done(done4), .out(out4)
    );

    assign obs_busy = sel4 ? busy4 : busy1;
    assign obs_done = sel4 ? done4 : done1;
    assign obs_out  = sel4 ? out4  : out1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one request so that the next rising edge samples it; returns 1 time unit into cycle 1.
    task automatic applyStimulus(input logic [1:0] m, input logic [4:0] s, input logic [31:0] d);
        @(negedge clk);
        mode  = m;
        shamt = s;
        in    = d;
        if (sel4) start4 = 1'b1;
        else      start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        in     = 32'hA5A5_A5A5;
        mode   = ~m;
        shamt  = ~s;
    endtask

    task automatic runOp(input string tag, input logic [1:0] m, input logic [4:0] s,
                         input logic [31:0] d, input logic [31:0] exp_out, input int exp_lat);
        int busy_cnt;
        int done_cnt;
        int first_done;
        busy_cnt   = 0;
        done_cnt   = 0;
        first_done = 0;
        applyStimulus(m, s, d);
        for (int c = 1; c <= exp_lat + 3; c++) begin
            if (obs_busy) busy_cnt++;
            if (obs_done) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({tag, " out"}, obs_out, exp_out);
        checkOutput({tag, " latency"}, 32'(first_done), 32'(exp_lat));
        checkOutput({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    endtask

    initial begin
        int done_cnt;
        int first_done;
        compared   = 0;
        mismatched = 0;
        sel4   = 1'b0;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        mode   = 2'b00;
        shamt  = 5'd0;
        in     = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out1",  out1, 32'h0);
        checkOutput("reset busy1", 32'(busy1), 32'd0);
        checkOutput("reset done1", 32'(done1), 32'd0);
        checkOutput("reset out4",  out4, 32'h0);
        checkOutput("reset busy4", 32'(busy4), 32'd0);
        checkOutput("reset done4", 32'(done4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] STEP=1 directed operations");
        runOp("sll16",     2'b00, 5'd16, 32'h0000_FFFF, 32'hFFFF_0000, 17);
        runOp("sra31",     2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32);
        runOp("srl31",     2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 32);
        runOp("rotl4",     2'b11, 5'd4,  32'h8000_0001, 32'h0000_0018, 5);
        runOp("sra4_pos",  2'b10, 5'd4,  32'h4000_0000, 32'h0400_0000, 5);
        runOp("rotl8",     2'b11, 5'd8,  32'hF000_000F, 32'h0000_0FF0, 9);
        runOp("srl1",      2'b01, 5'd1,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 2);
        for (int m = 0; m < 4; m++) begin
            runOp($sformatf("zero_m%0d", m), 2'(m), 5'd0, 32'h1234_5678, 32'h1234_5678, 1);
        end

        $display("[TB] start during busy and done");
        done_cnt   = 0;
        first_done = 0;
        applyStimulus(2'b00, 5'd16, 32'h0000_FFFF);
        for (int c = 1; c <= 24; c++) begin
            if (c == 3 || c == 17) begin
                start1 = 1'b1;
                in     = 32'hDEAD_BEEF;
                mode   = 2'b01;
                shamt  = 5'd3;
            end else begin
                start1 = 1'b0;
                in     = 32'(c);
            end
            if (done1) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
            @(posedge clk);
            #1;
        end
        start1 = 1'b0;
        checkOutput("ignore out",         out1, 32'hFFFF_0000);
        checkOutput("ignore latency",     32'(first_done), 32'd17);
        checkOutput("ignore done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("ignore busy_after",  32'(busy1), 32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(2'b00, 5'd16, 32'h0000_FFFF);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort out",  out1, 32'h0);
        checkOutput("abort busy", 32'(busy1), 32'd0);
        checkOutput("abort done", 32'(done1), 32'd0);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done1) done_cnt++;
            @(posedge clk);
            #1;
        end
        checkOutput("abort no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort out_hold", out1, 32'h0);
        runOp("after_abort", 2'b00, 5'd3, 32'h0000_0001, 32'h0000_0008, 4);

        $display("[TB] STEP=4 operations");
        sel4 = 1'b1;
        runOp("s4_sll17",  2'b00, 5'd17, 32'h0000_0001, 32'h0002_0000, 6);
        runOp("s4_rotl4",  2'b11, 5'd4,  32'h8000_0001, 32'h0000_0018, 2);
        runOp("s4_sra31",  2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 9);
        runOp("s4_zero",   2'b01, 5'd0,  32'hCAFE_F00D, 32'hCAFE_F00D, 1);
        checkOutput("s4_dut1_hold", out1, 32'h0000_0008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
